// File: rtl/fp_pow_ctrl.sv
// fp_pow_ctrl: sequencer computing base^n for an IEEE754 single base and an
// unsigned integer exponent n. It uses right-to-left square-and-multiply over an
// external sequential fp multiplier.
//
// Optional build macro: FP_POW_TIMEOUT_EN. When it is defined, each multiply is
// abandoned after TIMEOUT wait cycles without mul_done. The result is then a qNaN
// and the sticky timeout flag is set.
//
// Ports:
//   CLK, RST         clock; synchronous active-high reset
//   start, base, n   request (accepted only while idle), operand capture
//   mul_a, mul_b     multiplier operands, held stable through each wait
//   mul_start        one-cycle multiply launch
//   mul_result, mul_done, mul_overflow, mul_underflow  multiplier return
//   result           final base^n, held until the next run overwrites it
//   done             one-cycle completion pulse
//   busy             high from the cycle after the accepted start through done
//   overflow, underflow, timeout  sticky abort causes, cleared on accepted start
module fp_pow_ctrl #(
    parameter int NW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [31:0]   base,
    input  logic [NW-1:0] n,
    output logic [31:0]   mul_a,
    output logic [31:0]   mul_b,
    output logic          mul_start,
    input  logic [31:0]   mul_result,
    input  logic          mul_done,
    input  logic          mul_overflow,
    input  logic          mul_underflow,
    output logic [31:0]   result,
    output logic          done,
    output logic          busy,
    output logic          overflow,
    output logic          underflow,
    output logic          timeout
);

    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ACC_ISSUE, S_ACC_WAIT,
        S_SQ_ISSUE, S_SQ_WAIT, S_ABORT, S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   sq_q, sq_d;
    logic [NW-1:0] e_q, e_d;
    logic          neg_q, neg_d;            // sign of the final result
    logic          sq_shift_q, sq_shift_d;  // squaring must also consume e[0]
    logic          ab_ovf_q, ab_ovf_d;      // abort cause: overflow has priority
    logic [31:0]   result_q, result_d;
    logic [31:0]   mul_a_q, mul_a_d;
    logic [31:0]   mul_b_q, mul_b_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          waiting;
    logic          tmo_hit;

    assign waiting = (state_q == S_ACC_WAIT) || (state_q == S_SQ_WAIT);

`ifdef FP_POW_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // A mul_done on the last allowed cycle still wins over the timeout.
    assign tmo_hit = waiting && !mul_done && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (mul_start) begin
            cnt_d = '0;
        end else if (waiting && !mul_done && !tmo_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == S_IDLE && start) begin
            tmo_d = 1'b0;
        end else if (tmo_hit) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    // Never true; the parameter stays referenced in this build.
    assign tmo_hit = 1'b0 && (TIMEOUT > 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sq_d       = sq_q;
        e_d        = e_q;
        neg_d      = neg_q;
        sq_shift_d = sq_shift_q;
        ab_ovf_d   = ab_ovf_q;
        result_d   = result_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = FP_ONE;
                    sq_d    = base;
                    e_d     = n;
                    neg_d   = base[31] & n[0];
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (e_q == '0) begin
                    result_d = acc_q;
                    state_d  = S_FINISH;
                end else if (sq_q[30:0] == 31'd0) begin
                    // Zero base: the multiplier cannot take zero operands.
                    result_d = {neg_q, 31'd0};
                    state_d  = S_FINISH;
                end else if (e_q[0]) begin
                    mul_a_d = acc_q;
                    mul_b_d = sq_q;
                    state_d = S_ACC_ISSUE;
                end else begin
                    mul_a_d    = sq_q;
                    mul_b_d    = sq_q;
                    sq_shift_d = 1'b1;
                    state_d    = S_SQ_ISSUE;
                end
            end
            S_ACC_ISSUE: state_d = S_ACC_WAIT;
            S_ACC_WAIT: begin
                if (mul_done) begin
                    if (mul_overflow || mul_underflow) begin
                        ab_ovf_d = mul_overflow;
                        state_d  = S_ABORT;
                    end else begin
                        acc_d = mul_result;
                        e_d   = e_q >> 1;
                        if ((e_q >> 1) == '0) begin
                            // Last bit consumed: no trailing square.
                            result_d = mul_result;
                            state_d  = S_FINISH;
                        end else begin
                            mul_a_d    = sq_q;
                            mul_b_d    = sq_q;
                            sq_shift_d = 1'b0;
                            state_d    = S_SQ_ISSUE;
                        end
                    end
                end else if (tmo_hit) begin
                    result_d = FP_QNAN;
                    state_d  = S_FINISH;
                end
            end
            S_SQ_ISSUE: state_d = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mul_done) begin
                    if (mul_overflow || mul_underflow) begin
                        ab_ovf_d = mul_overflow;
                        state_d  = S_ABORT;
                    end else begin
                        sq_d = mul_result;
                        if (sq_shift_q) begin
                            e_d = e_q >> 1;
                        end
                        state_d = S_CHECK;
                    end
                end else if (tmo_hit) begin
                    result_d = FP_QNAN;
                    state_d  = S_FINISH;
                end
            end
            S_ABORT: begin
                if (ab_ovf_q) begin
                    ovf_d    = 1'b1;
                    result_d = {neg_q, 8'hFF, 23'd0};
                end else begin
                    unf_d    = 1'b1;
                    result_d = {neg_q, 31'd0};
                end
                state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Working registers are only read after an accepted start loads them.
    always_ff @(posedge CLK) begin
        acc_q      <= acc_d;
        sq_q       <= sq_d;
        e_q        <= e_d;
        neg_q      <= neg_d;
        sq_shift_q <= sq_shift_d;
        ab_ovf_q   <= ab_ovf_d;
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_start = (state_q == S_ACC_ISSUE) || (state_q == S_SQ_ISSUE);
    assign result    = result_q;
    assign done      = (state_q == S_FINISH);
    assign busy      = (state_q != S_IDLE);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fp_pow_ctrl.sv
// Testbench for fp_pow_ctrl: a behavioural fp multiplier with random latency,
// a closed-form power reference model, and directed plus random runs.
module tb_fp_pow_ctrl;

    localparam int NW      = 8;
    localparam int TIMEOUT = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base = '0;
    logic [NW-1:0] n = '0;
    logic [31:0]   mul_a, mul_b, mul_result;
    logic          mul_start, mul_done, mul_overflow, mul_underflow;
    logic [31:0]   result;
    logic          done, busy, overflow, underflow, timeout;

    fp_pow_ctrl #(.NW(NW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .start(start), .base(base), .n(n),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_result(mul_result), .mul_done(mul_done),
        .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
        .result(result), .done(done), .busy(busy),
        .overflow(overflow), .underflow(underflow), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Multiplier model state
    bit hang = 1'b0;         // never answer
    bit inject_done = 1'b0;  // unsolicited mul_done
    int nmul = 0;            // mul_start pulses seen

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    // Truncating single-precision multiply for normal operands; {ovf, unf, product}.
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] fr;
        int ex;
        p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        ex = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            ex++;
            fr = p[46:24];
        end else begin
            fr = p[45:23];
        end
        return {ex >= 255, ex <= 0, a[31] ^ b[31], ex[7:0], fr};
    endfunction

    // base^nn for a base whose significand is 1.xx (only the top two fraction bits used):
    // (s/4)^nn * 2^(nn*(E-127)) computed as an exact integer power, then packed.
    function automatic logic [31:0] ref_pow(input logic [31:0] b, input int nn);
        longint p;
        logic [63:0] t;
        int s, k, ex;
        s = int'({1'b1, b[22:21]});
        p = 1;
        for (int i = 0; i < nn; i++) p = p * s;
        k = 0;
        for (int i = 0; i < 40; i++) if (p[i]) k = i;
        ex = k + nn * (int'(b[30:23]) - 127) - 2 * nn + 127;
        t  = 64'(p) << (23 - k);
        return {b[31] & (nn % 2 == 1), ex[7:0], t[22:0]};
    endfunction

    // Multiplies needed: popcount(n) + bitlength(n) - 1, none for n=0.
    function automatic int exp_muls(input int nn);
        int l, pc;
        l = 0;
        pc = 0;
        for (int i = 0; i < 32; i++) if (nn[i]) begin l = i + 1; pc++; end
        return (nn == 0) ? 0 : pc + l - 1;
    endfunction

    // Multiplier responder: answers 1..4 cycles after each mul_start.
    initial begin
        logic [31:0] ra, rb;
        logic [33:0] pr;
        int pend;
        pend = 0;
        ra = '0;
        rb = '0;
        mul_done = 1'b0;
        mul_result = '0;
        mul_overflow = 1'b0;
        mul_underflow = 1'b0;
        forever begin
            @(negedge CLK);
            mul_done = 1'b0;
            mul_overflow = 1'b0;
            mul_underflow = 1'b0;
            if (inject_done) begin
                mul_done = 1'b1;
                mul_result = 32'h40000000;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    pr = fmul(ra, rb);
                    mul_result = pr[31:0];
                    mul_overflow = pr[33];
                    mul_underflow = pr[32];
                    mul_done = 1'b1;
                end
            end
            if (mul_start) begin
                nmul++;
                if (!hang) begin
                    ra = mul_a;
                    rb = mul_b;
                    pend = $urandom_range(1, 4);
                end
            end
        end
    end

    // One request from a negedge; returns result at the done cycle, cycles from
    // the start edge to done, and multiplies issued.
    task automatic run(input logic [31:0] b, input logic [NW-1:0] nn, input bit glitch,
                       output logic [31:0] r, output int cyc, output int muls);
        int m0;
        bit got;
        got = 1'b0;
        m0 = nmul;
        base = b;
        n = nn;
        start = 1'b1;
        cyc = 0;
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk1("busy_after_start", busy, 1'b1);
            if (glitch && cyc == 3) begin
                start = 1'b1;
                base = 32'h40400000;
                n = 8'd1;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk1("done_seen", got, 1'b1);
        r = result;
        muls = nmul - m0;
        @(negedge CLK);
        chk1("done_one_cycle", done, 1'b0);
        chk1("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [31:0] r, b;
        int cyc, muls, nn, ex, sg, mt;
        bit seen;

        repeat (3) @(negedge CLK);
        chk("rst_result", result, 32'h0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mul_start", mul_start, 1'b0);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_mul_b", mul_b, 32'h0);
        chk1("rst_overflow", overflow, 1'b0);
        chk1("rst_underflow", underflow, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // 2.0^5 with a start pulse mid-run that must be ignored
        run(32'h40000000, 8'd5, 1'b1, r, cyc, muls);
        chk("pow_2_5", r, 32'h42000000);
        chk("muls_2_5", muls, 4);
        chk1("flags_2_5", overflow | underflow, 1'b0);

        run(32'h3FC00000, 8'd2, 1'b0, r, cyc, muls);
        chk("pow_1p5_2", r, 32'h40100000);
        chk("muls_1p5_2", muls, 2);

        run(32'hC0000000, 8'd3, 1'b0, r, cyc, muls);
        chk("pow_m2_3", r, 32'hC1000000);
        chk("muls_m2_3", muls, 3);

        run(32'hC0000000, 8'd0, 1'b0, r, cyc, muls);
        chk("pow_n0", r, 32'h3F800000);
        chk("cyc_n0", cyc, 2);
        chk("muls_n0", muls, 0);

        run(32'h80000000, 8'd3, 1'b0, r, cyc, muls);
        chk("pow_mzero_3", r, 32'h80000000);
        chk("muls_mzero_3", muls, 0);
        run(32'h80000000, 8'd4, 1'b0, r, cyc, muls);
        chk("pow_mzero_4", r, 32'h00000000);
        chk("muls_mzero_4", muls, 0);

        run(32'h40000000, 8'd200, 1'b0, r, cyc, muls);
        chk("pow_ovf", r, 32'h7F800000);
        chk1("ovf_flag", overflow, 1'b1);
        chk1("ovf_unf_flag", underflow, 1'b0);
        run(32'h3FC00000, 8'd2, 1'b0, r, cyc, muls);
        chk1("ovf_cleared", overflow, 1'b0);
        chk("pow_after_ovf", r, 32'h40100000);

        // -(2^-100)^3: first product fine, the square underflows
        run(32'h8D800000, 8'd3, 1'b0, r, cyc, muls);
        chk("pow_unf", r, 32'h80000000);
        chk1("unf_flag", underflow, 1'b1);
        chk1("unf_ovf_flag", overflow, 1'b0);

        for (int t = 0; t < 12; t++) begin
            sg = $urandom_range(0, 1);
            ex = $urandom_range(122, 132);
            mt = $urandom_range(0, 3);
            nn = $urandom_range(0, 7);
            b = {sg[0], ex[7:0], mt[1:0], 21'd0};
            run(b, nn[NW-1:0], 1'b0, r, cyc, muls);
            chk("rand_pow", r, ref_pow(b, nn));
            chk("rand_muls", muls, exp_muls(nn));
            chk1("rand_flags", overflow | underflow | timeout, 1'b0);
        end

        // Reset while waiting on the multiplier, then a stray mul_done
        hang = 1'b1;
        base = 32'h40000000;
        n = 8'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        chk1("wait_busy", busy, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_result", result, 32'h0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_mul_start", mul_start, 1'b0);
        chk("midrst_mul_a", mul_a, 32'h0);
        chk("midrst_mul_b", mul_b, 32'h0);
        chk1("midrst_flags", overflow | underflow | timeout, 1'b0);
        RST = 1'b0;
        hang = 1'b0;
        @(posedge CLK);
        inject_done = 1'b1;
        @(posedge CLK);
        inject_done = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            seen = seen | done | busy | mul_start;
        end
        chk1("late_done_ignored", seen, 1'b0);

`ifdef FP_POW_TIMEOUT_EN
        hang = 1'b1;
        run(32'h40000000, 8'd1, 1'b0, r, cyc, muls);
        hang = 1'b0;
        chk("tmo_result", r, 32'h7FC00000);
        chk1("tmo_flag", timeout, 1'b1);
        chk("tmo_cycles", cyc, TIMEOUT + 3);
        run(32'h3FC00000, 8'd2, 1'b0, r, cyc, muls);
        chk1("tmo_cleared", timeout, 1'b0);
        chk("pow_after_tmo", r, 32'h40100000);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
